// File: rtl/dmem_wbuf.sv
// Data-memory front end with a posted store buffer; loads are forwarded from
// the buffer on a hit, otherwise a single blocking read goes out to memory.
module dmem_wbuf #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] cpu_addr,
  input  logic        cpu_we,
  input  logic        cpu_re,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  // state   | meaning
  // IDLE    | accept stores, forward hits, drain buffer head
  // RD_REQ  | load miss issued, waiting for grant
  // RD_WAIT | read granted, waiting for read data
  // RD_DONE | present captured read data for one cycle

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0]   FULL  = (PW+1)'(DEPTH);
  localparam logic [PW-1:0] P_ONE = PW'(1);
  localparam logic [PW:0]   C_ONE = (PW+1)'(1);

  typedef enum logic [1:0] {IDLE, RD_REQ, RD_WAIT, RD_DONE} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [PW:0]   count_q, count_d;
  logic [29:0]   ent_addr_q [DEPTH];
  logic [29:0]   ent_addr_d [DEPTH];
  logic [31:0]   ent_data_q [DEPTH];
  logic [31:0]   ent_data_d [DEPTH];
  logic [29:0]   rd_addr_q, rd_addr_d;
  logic [31:0]   rd_q, rd_d;

  logic          hit;
  logic [31:0]   hit_data;
  logic [PW-1:0] idx;
  logic          enq, pop, load_cyc;
  logic          unused_addr_bits;

  assign unused_addr_bits = ^cpu_addr[1:0];
  assign load_cyc = cpu_re && !cpu_we;

  // Walk oldest to youngest so the last match seen is the youngest store.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PW'(i);
      if (((PW+1)'(i) < count_q) && (ent_addr_q[idx] == cpu_addr[31:2])) begin
        hit      = 1'b1;
        hit_data = ent_data_q[idx];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    rd_addr_d = rd_addr_q;
    rd_d      = rd_q;
    enq       = 1'b0;
    pop       = 1'b0;
    cpu_rdata = '0;
    cpu_stall = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (rst_n) begin
      case (state_q)
        IDLE: begin
          if (cpu_we) begin
            if (count_q != FULL) enq = 1'b1;
            else                 cpu_stall = 1'b1;
          end else if (cpu_re) begin
            if (hit) begin
              cpu_rdata = hit_data;
            end else begin
              cpu_stall = 1'b1;
              mem_req   = 1'b1;
              mem_addr  = {cpu_addr[31:2], 2'b00};
              rd_addr_d = cpu_addr[31:2];
              state_d   = mem_gnt ? RD_WAIT : RD_REQ;
            end
          end
          // Any load owns the cycle: a hit needs no memory op, a miss has priority.
          if (!load_cyc && (count_q != '0)) begin
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = {ent_addr_q[head_q], 2'b00};
            mem_wdata = ent_data_q[head_q];
            pop       = mem_gnt;
          end
        end
        RD_REQ: begin
          cpu_stall = 1'b1;
          mem_req   = 1'b1;
          mem_addr  = {rd_addr_q, 2'b00};
          if (mem_gnt) state_d = RD_WAIT;
        end
        RD_WAIT: begin
          cpu_stall = 1'b1;
          if (mem_rvalid) begin
            rd_d    = mem_rdata;
            state_d = RD_DONE;
          end
        end
        RD_DONE: begin
          cpu_rdata = rd_q;
          state_d   = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    ent_addr_d = ent_addr_q;
    ent_data_d = ent_data_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    if (enq) begin
      ent_addr_d[tail_q] = cpu_addr[31:2];
      ent_data_d[tail_q] = cpu_wdata;
      tail_d             = tail_q + P_ONE;
    end
    if (pop) head_d = head_q + P_ONE;
    if (enq && !pop)      count_d = count_q + C_ONE;
    else if (!enq && pop) count_d = count_q - C_ONE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      rd_addr_q <= '0;
      rd_q      <= '0;
    end else begin
      state_q   <= state_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      rd_addr_q <= rd_addr_d;
      rd_q      <= rd_d;
    end
  end

  // Entry storage needs no reset; validity comes from head/count.
  always_ff @(posedge clk) begin
    ent_addr_q <= ent_addr_d;
    ent_data_q <= ent_data_d;
  end

endmodule

// File: tb/tb_dmem_wbuf.sv
// Directed bench for dmem_wbuf: inputs change 1ns after the rising edge,
// outputs are checked on the falling edge.
module tb_dmem_wbuf;
  logic        clk;
  logic        rst_n;
  logic [31:0] cpu_addr;
  logic        cpu_we;
  logic        cpu_re;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  int n_chk = 0;
  int n_bad = 0;

  dmem_wbuf #(.DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_addr(cpu_addr), .cpu_we(cpu_we), .cpu_re(cpu_re),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic chk_idle_outs(input string tag);
    chk({tag, "_stall"}, {31'd0, cpu_stall}, 32'd0);
    chk({tag, "_req"},   {31'd0, mem_req},   32'd0);
    chk({tag, "_we"},    {31'd0, mem_we},    32'd0);
    chk({tag, "_addr"},  mem_addr,           32'd0);
    chk({tag, "_wdata"}, mem_wdata,          32'd0);
    chk({tag, "_rdata"}, cpu_rdata,          32'd0);
  endtask

  initial begin
    rst_n = 1'b0; cpu_addr = '0; cpu_we = 1'b0; cpu_re = 1'b0; cpu_wdata = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;

    // reset, with a store attempt that must be ignored
    nxt();
    cpu_we = 1'b1; cpu_addr = 32'h10; cpu_wdata = 32'hA0;
    mid(); chk_idle_outs("rst");
    nxt(); chk("rst_count", 32'(dut.count_q), 32'd0);

    // fill the buffer with no grant
    rst_n = 1'b1;
    mid(); chk("st0_stall", {31'd0, cpu_stall}, 32'd0); chk("st0_req", {31'd0, mem_req}, 32'd0);
    nxt(); cpu_addr = 32'h14; cpu_wdata = 32'hA1;
    mid(); chk("st1_stall", {31'd0, cpu_stall}, 32'd0);
    chk("st1_drain_req", {31'd0, mem_req}, 32'd1); chk("st1_drain_we", {31'd0, mem_we}, 32'd1);
    chk("st1_drain_addr", mem_addr, 32'h10); chk("st1_drain_wdata", mem_wdata, 32'hA0);
    nxt(); cpu_addr = 32'h18; cpu_wdata = 32'hA2;
    nxt(); cpu_addr = 32'h1C; cpu_wdata = 32'hA3;
    mid(); chk("st3_stall", {31'd0, cpu_stall}, 32'd0);
    nxt(); chk("full_count", 32'(dut.count_q), 32'd4);

    // fifth store stalls; a pop in the same cycle does not let it in
    cpu_addr = 32'h20; cpu_wdata = 32'hA4;
    mid(); chk("full_stall_a", {31'd0, cpu_stall}, 32'd1); chk("full_head", mem_addr, 32'h10);
    nxt();
    mid(); chk("full_stall_b", {31'd0, cpu_stall}, 32'd1);
    nxt(); mem_gnt = 1'b1;
    mid(); chk("pop_cyc_stall", {31'd0, cpu_stall}, 32'd1); chk("pop_cyc_addr", mem_addr, 32'h10);
    nxt(); mem_gnt = 1'b0;
    chk("after_pop_count", 32'(dut.count_q), 32'd3);
    mid(); chk("enq_stall", {31'd0, cpu_stall}, 32'd0); chk("new_head", mem_addr, 32'h14);
    nxt(); chk("refill_count", 32'(dut.count_q), 32'd4);
    cpu_we = 1'b0; mem_gnt = 1'b1;
    for (int k = 0; k < 4; k++) begin
      mid();
      chk("drain1_addr", mem_addr, 32'h14 + 32'(4 * k));
      chk("drain1_wdata", mem_wdata, 32'hA1 + 32'(k));
      chk("drain1_we", {31'd0, mem_we}, 32'd1);
      nxt();
    end
    mem_gnt = 1'b0;
    mid(); chk("drain1_empty_req", {31'd0, mem_req}, 32'd0);
    chk("drain1_count", 32'(dut.count_q), 32'd0);

    // forwarding: youngest of two stores to the same word wins
    nxt(); cpu_we = 1'b1; cpu_addr = 32'h40; cpu_wdata = 32'h11;
    nxt(); cpu_wdata = 32'h22;
    nxt(); cpu_we = 1'b0; cpu_re = 1'b1; cpu_addr = 32'h40;
    mid(); chk("hit_rdata", cpu_rdata, 32'h22);
    chk("hit_stall", {31'd0, cpu_stall}, 32'd0); chk("hit_req", {31'd0, mem_req}, 32'd0);
    nxt(); cpu_re = 1'b0; mem_gnt = 1'b1;
    mid(); chk("noload_rdata", cpu_rdata, 32'd0);
    chk("drain2a_addr", mem_addr, 32'h40); chk("drain2a_wdata", mem_wdata, 32'h11);
    nxt();
    mid(); chk("drain2b_wdata", mem_wdata, 32'h22);
    nxt(); mem_gnt = 1'b0;
    mid(); chk("drain2_empty_req", {31'd0, mem_req}, 32'd0);

    // miss with immediate grant and next-cycle data
    nxt(); cpu_re = 1'b1; cpu_addr = 32'h80; mem_gnt = 1'b1;
    mid(); chk("miss_stall1", {31'd0, cpu_stall}, 32'd1);
    chk("miss_req", {31'd0, mem_req}, 32'd1); chk("miss_we", {31'd0, mem_we}, 32'd0);
    chk("miss_addr", mem_addr, 32'h80);
    nxt(); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF;
    mid(); chk("miss_stall2", {31'd0, cpu_stall}, 32'd1); chk("wait_req", {31'd0, mem_req}, 32'd0);
    nxt(); mem_rvalid = 1'b0; mem_rdata = '0;
    mid(); chk("done_stall", {31'd0, cpu_stall}, 32'd0); chk("done_rdata", cpu_rdata, 32'hDEADBEEF);
    nxt(); cpu_re = 1'b0;
    mid(); chk("post_done_rdata", cpu_rdata, 32'd0);

    // read beats buffered writes; writes then drain in order
    nxt(); cpu_we = 1'b1; cpu_addr = 32'h100; cpu_wdata = 32'h1;
    nxt(); cpu_addr = 32'h104; cpu_wdata = 32'h2;
    nxt(); cpu_we = 1'b0; cpu_re = 1'b1; cpu_addr = 32'h202;
    mid(); chk("prio_we", {31'd0, mem_we}, 32'd0); chk("prio_addr", mem_addr, 32'h200);
    chk("prio_stall", {31'd0, cpu_stall}, 32'd1);
    nxt(); mem_gnt = 1'b1;
    mid(); chk("rdreq_req", {31'd0, mem_req}, 32'd1); chk("rdreq_we", {31'd0, mem_we}, 32'd0);
    chk("rdreq_addr", mem_addr, 32'h200); chk("rdreq_stall", {31'd0, cpu_stall}, 32'd1);
    nxt(); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h55;
    mid(); chk("rdwait_req", {31'd0, mem_req}, 32'd0); chk("rdwait_stall", {31'd0, cpu_stall}, 32'd1);
    nxt(); mem_rvalid = 1'b0;
    mid(); chk("rddone_rdata", cpu_rdata, 32'h55); chk("rddone_req", {31'd0, mem_req}, 32'd0);
    nxt(); cpu_re = 1'b0; mem_gnt = 1'b1;
    mid(); chk("order1_addr", mem_addr, 32'h100); chk("order1_wdata", mem_wdata, 32'h1);
    chk("order1_we", {31'd0, mem_we}, 32'd1);
    nxt();
    mid(); chk("order2_addr", mem_addr, 32'h104); chk("order2_wdata", mem_wdata, 32'h2);
    nxt(); mem_gnt = 1'b0;
    mid(); chk("order_empty_req", {31'd0, mem_req}, 32'd0);

    // reset during RD_WAIT with three stores buffered
    nxt(); cpu_we = 1'b1; cpu_addr = 32'h300; cpu_wdata = 32'h3;
    nxt(); cpu_addr = 32'h304;
    nxt(); cpu_addr = 32'h308;
    nxt(); cpu_we = 1'b0; cpu_re = 1'b1; cpu_addr = 32'h400; mem_gnt = 1'b1;
    mid(); chk("rst_miss_addr", mem_addr, 32'h400);
    nxt(); mem_gnt = 1'b0;
    mid(); chk("rst_wait_stall", {31'd0, cpu_stall}, 32'd1);
    rst_n = 1'b0;
    nxt(); cpu_re = 1'b0;
    chk("midrst_count", 32'(dut.count_q), 32'd0);
    mid(); chk_idle_outs("midrst");
    nxt(); rst_n = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hBAD0;
    mid(); chk_idle_outs("late_rvalid");
    nxt(); mem_rvalid = 1'b0;
    mid(); chk_idle_outs("post_rst");
    chk("post_rst_count", 32'(dut.count_q), 32'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
